// File: rtl/ak4619_target_if.sv
// ak4619_target_if: serial pins and sample-side bus of the AK4619 target port.
// The slave modport is the target (codec stand-in); master is the far end.
interface ak4619_target_if #(
  parameter int WIDTH = 16
);
  logic                    bick;
  logic                    lrck;
  logic                    sdin;
  logic                    sdout;
  logic signed [WIDTH-1:0] rx_sample0;
  logic signed [WIDTH-1:0] rx_sample1;
  logic                    rx_valid;
  logic signed [WIDTH-1:0] tx_sample0;
  logic signed [WIDTH-1:0] tx_sample1;
  logic                    tx_latch;
  logic                    locked;
  logic                    frame_err;
  logic [7:0]              err_count;

  modport slave (
    input  bick, lrck, sdin, tx_sample0, tx_sample1,
    output sdout, rx_sample0, rx_sample1, rx_valid, tx_latch,
           locked, frame_err, err_count
  );

  modport master (
    output bick, lrck, sdin, tx_sample0, tx_sample1,
    input  sdout, rx_sample0, rx_sample1, rx_valid, tx_latch,
           locked, frame_err, err_count
  );
endinterface

// File: rtl/ak4619_target.sv
// ak4619_target: codec-side 2-channel serial audio port. bick/lrck come from
// the far end and are oversampled on clk; sdin is deserialised into two
// signed words per frame and two words are serialised onto sdout.
// Optional feature macro: AK4619_TARGET_FRAME_CHECK_EN enables slot-length
// checking (frame_err pulse, saturating err_count, resync and frame drop).
module ak4619_target #(
  parameter int WIDTH      = 16,
  parameter int SLOT_BITS  = 32,
  parameter int DATA_DELAY = 0
) (
  input  logic            clk,
  input  logic            rst,
  ak4619_target_if.slave  bus
);

`ifdef AK4619_TARGET_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  localparam logic [5:0] SLOT_CNT = 6'(SLOT_BITS);
  localparam logic [5:0] LAST_BIT = 6'(DATA_DELAY + WIDTH - 1);
  localparam int         LW       = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              bick_pipe_q, bick_pipe_d;
  logic [2:0]              lrck_pipe_q, lrck_pipe_d;
  logic [1:0]              sdin_pipe_q, sdin_pipe_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic                    ch_q, ch_d;
  logic [WIDTH-2:0]        rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]        stage_q, stage_d;
  logic                    ch0_ok_q, ch0_ok_d;
  logic [WIDTH-1:0]        rx_sample0_q, rx_sample0_d;
  logic [WIDTH-1:0]        rx_sample1_q, rx_sample1_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0]        tx_hold0_q, tx_hold0_d;
  logic [WIDTH-1:0]        tx_hold1_q, tx_hold1_d;
  logic                    tx_latch_q, tx_latch_d;
  logic [WIDTH-1:0]        tx_shift_q, tx_shift_d;
  logic [LW-1:0]           tx_left_q, tx_left_d;
  logic                    sdout_q, sdout_d;
  logic                    locked_q, locked_d;
  logic                    frame_err_q, frame_err_d;
  logic [7:0]              err_count_q, err_count_d;

  logic                    bick_rise, bick_fall, lr_edge, lr_fall, lr_now, sdin_now;
  logic [5:0]              cnt_eff;
  logic                    ch_eff;
  logic                    slot_bad;
  logic                    in_window;
  logic [WIDTH-1:0]        rx_next;
  logic [WIDTH-1:0]        tx_word;

  // Edge events taken from the second and third synchroniser stages
  always_comb begin
    bick_rise = bick_pipe_q[1] & ~bick_pipe_q[2];
    bick_fall = ~bick_pipe_q[1] & bick_pipe_q[2];
    lr_now    = lrck_pipe_q[1];
    lr_edge   = lrck_pipe_q[1] ^ lrck_pipe_q[2];
    lr_fall   = ~lrck_pipe_q[1] & lrck_pipe_q[2];
    sdin_now  = sdin_pipe_q[1];
  end

  // Next-state logic: lock FSM, slot counter, receive and transmit paths
  always_comb begin
    bick_pipe_d  = {bick_pipe_q[1:0], bus.bick};
    lrck_pipe_d  = {lrck_pipe_q[1:0], bus.lrck};
    sdin_pipe_d  = {sdin_pipe_q[0], bus.sdin};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_d         = ch_q;
    rx_shift_d   = rx_shift_q;
    stage_d      = stage_q;
    ch0_ok_d     = ch0_ok_q;
    rx_sample0_d = rx_sample0_q;
    rx_sample1_d = rx_sample1_q;
    rx_valid_d   = 1'b0;
    tx_hold0_d   = tx_hold0_q;
    tx_hold1_d   = tx_hold1_q;
    tx_latch_d   = 1'b0;
    tx_shift_d   = tx_shift_q;
    tx_left_d    = tx_left_q;
    sdout_d      = sdout_q;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    slot_bad     = 1'b0;
    cnt_eff      = bit_cnt_q;
    ch_eff       = ch_q;
    rx_next      = {rx_shift_q, sdin_now};
    tx_word      = lr_now ? tx_hold1_q : bus.tx_sample0;

    // Lock: the first lrck falling edge starts channel 0 of a frame
    case (state_q)
      ST_UNLOCKED: begin
        if (lr_fall) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_UNLOCKED;
    endcase

    // An lrck edge clears the count before a coincident bick rise uses it
    if (lr_edge) begin
      cnt_eff = 6'd0;
      ch_eff  = lr_now;
    end else begin
      cnt_eff = bit_cnt_q;
      ch_eff  = ch_q;
    end
    if (bick_rise) begin
      bit_cnt_d = (cnt_eff == 6'd63) ? 6'd63 : cnt_eff + 6'd1;
    end else begin
      bit_cnt_d = cnt_eff;
    end
    ch_d = ch_eff;

    // Slot-length check: a short or long slot drops the frame and resyncs
    if (FRAME_CHECK && (state_q == ST_RUN) && lr_edge && (bit_cnt_q != SLOT_CNT)) begin
      slot_bad    = 1'b1;
      frame_err_d = 1'b1;
      err_count_d = (err_count_q == 8'd255) ? 8'd255 : err_count_q + 8'd1;
    end else begin
      slot_bad = 1'b0;
    end

    // A new frame, or a bad slot, invalidates any half-received frame
    if (lr_fall || slot_bad) begin
      ch0_ok_d = 1'b0;
    end else begin
      ch0_ok_d = ch0_ok_q;
    end

    // Receive: shift in only the data window of the slot, MSB first
    in_window = (int'(cnt_eff) >= DATA_DELAY) && (int'(cnt_eff) < DATA_DELAY + WIDTH);
    if ((state_d == ST_RUN) && bick_rise && in_window) begin
      rx_shift_d = rx_next[WIDTH-2:0];
      if (cnt_eff == LAST_BIT) begin
        if (ch_eff == 1'b0) begin
          stage_d  = rx_next;
          ch0_ok_d = 1'b1;
        end else if (ch0_ok_d) begin
          rx_sample0_d = stage_q;
          rx_sample1_d = rx_next;
          rx_valid_d   = 1'b1;
          ch0_ok_d     = 1'b0;
        end else begin
          ch0_ok_d = 1'b0;
        end
      end else begin
        stage_d = stage_q;
      end
    end else begin
      rx_shift_d = rx_shift_q;
    end

    // Transmit words are captured once per frame, on the lrck falling edge
    if (lr_fall) begin
      tx_hold0_d = bus.tx_sample0;
      tx_hold1_d = bus.tx_sample1;
      tx_latch_d = 1'b1;
    end else begin
      tx_latch_d = 1'b0;
    end

    // Transmit shifter: load wins over a coincident bick fall
    if (lr_edge) begin
      if (DATA_DELAY == 0) begin
        sdout_d    = tx_word[WIDTH-1];
        tx_shift_d = {tx_word[WIDTH-2:0], 1'b0};
        tx_left_d  = LW'(WIDTH - 1);
      end else begin
        sdout_d    = 1'b0;
        tx_shift_d = tx_word;
        tx_left_d  = LW'(WIDTH);
      end
    end else if (bick_fall) begin
      if (tx_left_q != LW'(0)) begin
        sdout_d    = tx_shift_q[WIDTH-1];
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        tx_left_d  = tx_left_q - LW'(1);
      end else begin
        sdout_d = 1'b0;
      end
    end else begin
      sdout_d = sdout_q;
    end

    // The line stays quiet until the port has locked
    if (state_d != ST_RUN) begin
      sdout_d = 1'b0;
    end else begin
      sdout_d = sdout_d;
    end

    locked_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      bick_pipe_q  <= 3'b000;
      lrck_pipe_q  <= 3'b000;
      sdin_pipe_q  <= 2'b00;
      bit_cnt_q    <= 6'd0;
      ch_q         <= 1'b0;
      rx_shift_q   <= '0;
      stage_q      <= '0;
      ch0_ok_q     <= 1'b0;
      rx_sample0_q <= '0;
      rx_sample1_q <= '0;
      rx_valid_q   <= 1'b0;
      tx_hold0_q   <= '0;
      tx_hold1_q   <= '0;
      tx_latch_q   <= 1'b0;
      tx_shift_q   <= '0;
      tx_left_q    <= '0;
      sdout_q      <= 1'b0;
      locked_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      bick_pipe_q  <= bick_pipe_d;
      lrck_pipe_q  <= lrck_pipe_d;
      sdin_pipe_q  <= sdin_pipe_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_q         <= ch_d;
      rx_shift_q   <= rx_shift_d;
      stage_q      <= stage_d;
      ch0_ok_q     <= ch0_ok_d;
      rx_sample0_q <= rx_sample0_d;
      rx_sample1_q <= rx_sample1_d;
      rx_valid_q   <= rx_valid_d;
      tx_hold0_q   <= tx_hold0_d;
      tx_hold1_q   <= tx_hold1_d;
      tx_latch_q   <= tx_latch_d;
      tx_shift_q   <= tx_shift_d;
      tx_left_q    <= tx_left_d;
      sdout_q      <= sdout_d;
      locked_q     <= locked_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.sdout      = sdout_q;
  assign bus.rx_sample0 = rx_sample0_q;
  assign bus.rx_sample1 = rx_sample1_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_latch   = tx_latch_q;
  assign bus.locked     = locked_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_count  = err_count_q;

endmodule
